// File: rtl/read_level_ctrl_block.sv
// ============================================================================
// Module      : read_level_ctrl_block
// Description : Read-side pointer controller for an asynchronous FIFO.
//               Keeps the binary/gray read pointers and decodes the
//               synchronised gray write pointer. It produces a registered
//               fill level, empty and almost-empty flags, and sticky
//               underflow and pointer-error status.
// Revision    : 1.0 - initial release
//
// Optional feature macro: READ_UNDERFLOW_COUNT_EN
//   When defined, adds an 8-bit saturating count of rejected pops
//   (read_underflow_count_o).
//
// Ports:
//   read_clock_i            read-domain clock
//   read_reset_i            synchronous active-high reset
//   read_inc_i              pop request (ignored while empty)
//   write_to_read_pointer_i gray write pointer, already synchronised
//   read_threshold_i        almost-empty threshold (quasi-static)
//   read_clear_i            clears sticky status
//   read_address_o          binary memory read address
//   read_pointer_o          registered gray read pointer
//   read_level_o            registered fill level, 0..2^ADDR_SIZE
//   read_empty_o            FIFO empty
//   read_almost_empty_o     level <= threshold
//   read_underflow_o        sticky: pop attempted while empty
//   read_ptr_error_o        sticky: decoded level exceeded depth
//   read_underflow_count_o  (optional) saturating rejected-pop count
// ============================================================================
`default_nettype none

module read_level_ctrl_block #(
  parameter int ADDR_SIZE   = 4,
  parameter bit RESET_EMPTY = 1'b1
) (
  input  logic                 read_clock_i,
  input  logic                 read_reset_i,
  input  logic                 read_inc_i,
  input  logic [ADDR_SIZE:0]   write_to_read_pointer_i,
  input  logic [ADDR_SIZE:0]   read_threshold_i,
  input  logic                 read_clear_i,
  output logic [ADDR_SIZE-1:0] read_address_o,
  output logic [ADDR_SIZE:0]   read_pointer_o,
  output logic [ADDR_SIZE:0]   read_level_o,
  output logic                 read_empty_o,
  output logic                 read_almost_empty_o,
  output logic                 read_underflow_o,
  output logic                 read_ptr_error_o
`ifdef READ_UNDERFLOW_COUNT_EN
  ,
  output logic [7:0]           read_underflow_count_o
`endif
);

  // Depth expressed at pointer width: only the MSB is set.
  localparam logic [ADDR_SIZE:0] DEPTH = {1'b1, {ADDR_SIZE{1'b0}}};

  logic [ADDR_SIZE:0] rbin;
  logic [ADDR_SIZE:0] rbin_next;
  logic [ADDR_SIZE:0] read_gray_next;
  logic [ADDR_SIZE:0] wbin;
  logic [ADDR_SIZE:0] level_next;
  logic               pop;
  logic               reject;

  // A pop request seen while empty is rejected and only raises underflow.
  assign pop    = read_inc_i & ~read_empty_o;
  assign reject = read_inc_i &  read_empty_o;

  assign rbin_next      = rbin + {{ADDR_SIZE{1'b0}}, pop};
  assign read_gray_next = (rbin_next >> 1) ^ rbin_next;

  // Gray-to-binary conversion. Each binary bit is the XOR of every gray bit
  // at or above its position. Writing it as a reduction per bit keeps the
  // logic free of a combinational chain through wbin itself.
  for (genvar i = 0; i <= ADDR_SIZE; i++) begin : g_gray2bin
    assign wbin[i] = ^(write_to_read_pointer_i >> i);
  end

  // The difference wraps modulo 2^(ADDR_SIZE+1), so a legal level is always
  // 0..DEPTH. Anything larger means the synchronised pointer is corrupt.
  assign level_next = wbin - rbin_next;

  assign read_address_o = rbin[ADDR_SIZE-1:0];

  always_ff @(posedge read_clock_i) begin
    if (read_reset_i) begin
      rbin                <= '0;
      read_pointer_o      <= '0;
      read_level_o        <= '0;
      read_empty_o        <= RESET_EMPTY;
      read_almost_empty_o <= 1'b1;
      read_underflow_o    <= 1'b0;
      read_ptr_error_o    <= 1'b0;
    end else begin
      rbin                <= rbin_next;
      read_pointer_o      <= read_gray_next;
      read_level_o        <= level_next;
      // Empty comes from the gray compare, not from the level, so that a
      // corrupted level can never open the FIFO for reading.
      read_empty_o        <= (write_to_read_pointer_i == read_gray_next);
      read_almost_empty_o <= (level_next <= read_threshold_i);
      // Sticky flags: a new set event in the same cycle beats the clear.
      read_underflow_o    <= reject | (read_underflow_o & ~read_clear_i);
      read_ptr_error_o    <= (level_next > DEPTH) |
                             (read_ptr_error_o & ~read_clear_i);
    end
  end

`ifdef READ_UNDERFLOW_COUNT_EN
  always_ff @(posedge read_clock_i) begin
    if (read_reset_i) begin
      read_underflow_count_o <= 8'd0;
    end else if (reject) begin
      // An increment together with a clear restarts the count at one.
      if (read_clear_i) begin
        read_underflow_count_o <= 8'd1;
      end else if (read_underflow_count_o != 8'hFF) begin
        read_underflow_count_o <= read_underflow_count_o + 8'd1;
      end
    end else if (read_clear_i) begin
      read_underflow_count_o <= 8'd0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_read_level_ctrl_block.sv
// ============================================================================
// Module      : tb_read_level_ctrl_block
// Description : Self-checking bench for read_level_ctrl_block (ADDR_SIZE=4).
//               It applies a directed vector table and hand-written wrap and
//               underflow sequences. It then runs randomized stimulus against
//               an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_read_level_ctrl_block;

  localparam int A   = 4;
  localparam int W   = A + 1;
  localparam int MOD = 1 << W;   // 32
  localparam int DEP = 1 << A;   // 16

  logic         clk = 1'b0;
  logic         rst, inc, clr;
  logic [A:0]   wptr, thr;
  logic [A-1:0] addr;
  logic [A:0]   rptr, level;
  logic         empty, aempty, uflow, perr;
`ifdef READ_UNDERFLOW_COUNT_EN
  logic [7:0]   ucount;
`endif

  always #5 clk = ~clk;

  read_level_ctrl_block #(.ADDR_SIZE(A), .RESET_EMPTY(1'b1)) dut (
    .read_clock_i            (clk),
    .read_reset_i            (rst),
    .read_inc_i              (inc),
    .write_to_read_pointer_i (wptr),
    .read_threshold_i        (thr),
    .read_clear_i            (clr),
    .read_address_o          (addr),
    .read_pointer_o          (rptr),
    .read_level_o            (level),
    .read_empty_o            (empty),
    .read_almost_empty_o     (aempty),
    .read_underflow_o        (uflow),
    .read_ptr_error_o        (perr)
`ifdef READ_UNDERFLOW_COUNT_EN
    ,
    .read_underflow_count_o  (ucount)
`endif
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model (integer arithmetic) ----------------
  int m_rbin, m_level, m_cnt;
  bit m_empty, m_ae, m_uf, m_err;

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) % MOD;
  endfunction

  // Decode by searching for the binary value whose gray code matches.
  function automatic int ungray(input int g);
    for (int b = 0; b < MOD; b++)
      if (gray(b) == g) return b;
    return 0;
  endfunction

  task automatic model_edge();
    int wb, rn, lv;
    bit rej, pp;
    if (rst) begin
      m_rbin = 0; m_level = 0; m_empty = 1; m_ae = 1;
      m_uf = 0; m_err = 0; m_cnt = 0;
    end else begin
      rej = inc && m_empty;
      pp  = inc && !m_empty;
      wb  = ungray(int'(wptr));
      rn  = (m_rbin + (pp ? 1 : 0)) % MOD;
      lv  = (wb - rn + MOD) % MOD;
      m_empty = (wb == rn);
      m_ae    = (lv <= int'(thr));
      m_uf    = rej || (m_uf && !clr);
      m_err   = (lv > DEP) || (m_err && !clr);
      if (rej) m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      else if (clr) m_cnt = 0;
      m_rbin  = rn;
      m_level = lv;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, clock it, advance the model, settle.
  task automatic step(input bit r, input bit i, input int wp, input int th,
                      input bit c);
    rst = r; inc = i; wptr = W'(wp); thr = W'(th); clr = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".level"}, int'(level), m_level);
    check({tag, ".empty"}, int'(empty), int'(m_empty));
    check({tag, ".aempty"}, int'(aempty), int'(m_ae));
    check({tag, ".uflow"}, int'(uflow), int'(m_uf));
    check({tag, ".perr"}, int'(perr), int'(m_err));
    check({tag, ".addr"}, int'(addr), m_rbin % DEP);
    check({tag, ".rptr"}, int'(rptr), gray(m_rbin));
`ifdef READ_UNDERFLOW_COUNT_EN
    check({tag, ".ucount"}, int'(ucount), m_cnt);
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit r, i, c;
    int wp, th;
    int e_level; bit e_empty, e_ae, e_uf, e_err; int e_addr, e_rptr;
  } vec_t;

  vec_t vt[15];

  initial begin
    int wb;
    rst = 1; inc = 0; clr = 0; wptr = '0; thr = W'(2);

    //         r  i  c  wp  th  lvl emp ae uf er addr rptr
    vt[0]  = '{1, 0, 0,  0,  2,  0, 1, 1, 0, 0, 0, 0};  // reset
    vt[1]  = '{0, 0, 0,  0,  2,  0, 1, 1, 0, 0, 0, 0};  // idle empty
    vt[2]  = '{0, 0, 0,  7,  2,  5, 0, 0, 0, 0, 0, 0};  // wptr = gray(5)
    vt[3]  = '{0, 1, 0,  7,  2,  4, 0, 0, 0, 0, 1, 1};  // pop
    vt[4]  = '{0, 1, 0,  7,  2,  3, 0, 0, 0, 0, 2, 3};  // pop
    vt[5]  = '{0, 1, 0,  7,  2,  2, 0, 1, 0, 0, 3, 2};  // pop: level at threshold
    vt[6]  = '{0, 0, 0,  2,  2,  0, 1, 1, 0, 0, 3, 2};  // wptr = gray(3): empty
    vt[7]  = '{0, 1, 0,  2,  2,  0, 1, 1, 1, 0, 3, 2};  // pop while empty
    vt[8]  = '{0, 1, 1,  2,  2,  0, 1, 1, 1, 0, 3, 2};  // set wins over clear
    vt[9]  = '{0, 0, 1,  2,  2,  0, 1, 1, 0, 0, 3, 2};  // clear alone
    vt[10] = '{1, 0, 0,  0,  2,  0, 1, 1, 0, 0, 0, 0};  // reset
    vt[11] = '{0, 0, 0, 30,  2, 20, 0, 0, 0, 1, 0, 0};  // gray(20): pointer error
    vt[12] = '{0, 0, 1, 24,  2, 16, 0, 0, 0, 0, 0, 0};  // gray(16) full, clear
    vt[13] = '{0, 1, 0, 24,  2, 15, 0, 0, 0, 0, 1, 1};  // pop from full
    vt[14] = '{1, 1, 0, 24,  2,  0, 1, 1, 0, 0, 0, 0};  // reset beats pending pop

    for (int k = 0; k < 15; k++) begin
      step(vt[k].r, vt[k].i, vt[k].wp, vt[k].th, vt[k].c);
      check($sformatf("vec%0d.level", k), int'(level), vt[k].e_level);
      check($sformatf("vec%0d.empty", k), int'(empty), int'(vt[k].e_empty));
      check($sformatf("vec%0d.aempty", k), int'(aempty), int'(vt[k].e_ae));
      check($sformatf("vec%0d.uflow", k), int'(uflow), int'(vt[k].e_uf));
      check($sformatf("vec%0d.perr", k), int'(perr), int'(vt[k].e_err));
      check($sformatf("vec%0d.addr", k), int'(addr), vt[k].e_addr);
      check($sformatf("vec%0d.rptr", k), int'(rptr), vt[k].e_rptr);
    end

    // ---------------- wrap: write leads by 3, 40 in/out cycles ----------------
    step(1, 0, 0, 2, 0);
    wb = 3;
    step(0, 0, gray(wb), 2, 0);
    check("wrap.start_level", int'(level), 3);
    for (int k = 1; k <= 40; k++) begin
      wb = (wb + 1) % MOD;
      step(0, 1, gray(wb), 2, 0);
      check("wrap.level", int'(level), 3);
      check("wrap.rptr", int'(rptr), gray(k % MOD));
      check("wrap.empty", int'(empty), 0);
    end

`ifdef READ_UNDERFLOW_COUNT_EN
    // ---------------- saturating underflow count ----------------
    step(1, 0, 0, 2, 0);
    for (int k = 0; k < 300; k++) step(0, 1, 0, 2, 0);
    check("ucount.sat", int'(ucount), 255);
    step(0, 1, 0, 2, 1);
    check("ucount.inc_over_clear", int'(ucount), 1);
    step(0, 0, 0, 2, 1);
    check("ucount.clear", int'(ucount), 0);
`endif

    // ---------------- randomized run against the model ----------------
    step(1, 0, 0, 2, 0);
    check_model("rand.reset");
    wb = 0;
    begin
      int th = 2;
      int wp;
      bit r, i, c;
      for (int k = 0; k < 800; k++) begin
        if (k % 50 == 0) th = int'($urandom_range(0, 20));
        r = ($urandom_range(0, 63) == 0);
        i = $urandom_range(0, 1) == 1;
        c = ($urandom_range(0, 7) == 0);
        if (r) wb = 0;
        else if ($urandom_range(0, 1) == 1 && ((wb - m_rbin + MOD) % MOD) < DEP)
          wb = (wb + 1) % MOD;
        // Occasionally feed a corrupted (non-sequential) sync value.
        if ($urandom_range(0, 39) == 0) wp = int'($urandom_range(0, MOD - 1));
        else wp = gray(wb);
        step(r, i, wp, th, c);
        check_model("rand");
        // Re-align the write tracker after a corruption so traffic continues.
        if (wp != gray(wb)) wb = ungray(wp);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound so the run can never hang.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
